// File: rtl/pword_measure.sv
// pword_measure: phase offset of sig_dut against sig_ref as a DDS phase word, 2^PHASE_BITS per turn
module pword_measure #(
  parameter int CNT_W = 24,
  parameter int PHASE_BITS = 20,
  parameter int TIMEOUT = 16777215
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sig_ref,
  input  logic        sig_dut,
  output logic [23:0] Pword,
  output logic        pword_valid,
  output logic        busy,
  output logic        err_nodut,
  output logic        err_timeout
);
  localparam int DW = $clog2(PHASE_BITS);
  typedef enum logic [2:0] {IDLE, WAIT_REF, MEASURE, DIVIDE, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] ref_s, dut_s;
  logic r_edge, d_edge, closing, timeout, lag_now, q_bit, lag_ok;
  logic [CNT_W-1:0] cnt, lag, period, rem;
  logic [CNT_W:0] rem_sh;
  logic [PHASE_BITS-1:0] quo;
  logic [DW-1:0] div_cnt;
  assign r_edge = ref_s[1] & ~ref_s[2];
  assign d_edge = dut_s[1] & ~dut_s[2];
  assign closing = state == MEASURE && r_edge;
  assign timeout = state == MEASURE && !r_edge && cnt == CNT_W'(TIMEOUT);
  assign lag_now = lag_ok | d_edge;
  assign rem_sh = {rem, 1'b0};
  assign q_bit = rem_sh >= {1'b0, period};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (!en) state_nx = IDLE;
    else
      case (state)
        IDLE:     state_nx = WAIT_REF;
        WAIT_REF: state_nx = r_edge ? MEASURE : WAIT_REF;
        MEASURE:  state_nx = closing ? (lag_now ? DIVIDE : WAIT_REF) : (timeout ? WAIT_REF : MEASURE);
        DIVIDE:   state_nx = div_cnt == DW'(PHASE_BITS - 1) ? DONE : DIVIDE;
        DONE:     state_nx = WAIT_REF;
        default:  state_nx = IDLE;
      endcase
  end
  always_comb begin
    busy = state != IDLE;
    err_nodut = closing && !lag_now;
    err_timeout = timeout;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ref_s <= '0;
      dut_s <= '0;
      Pword <= '0;
      pword_valid <= 1'b0;
      cnt <= '0;
      lag <= '0;
      lag_ok <= 1'b0;
      period <= '0;
      rem <= '0;
      quo <= '0;
      div_cnt <= '0;
    end else begin
      ref_s <= {ref_s[1:0], sig_ref};
      dut_s <= {dut_s[1:0], sig_dut};
      pword_valid <= en && state == DONE;
      if (en && state == DONE) Pword <= 24'(quo);
      if (state == WAIT_REF && r_edge) begin
        cnt <= CNT_W'(1);
        lag <= '0;
        lag_ok <= d_edge;
      end else if (state == MEASURE) begin
        cnt <= cnt + CNT_W'(1);
        if (d_edge && !lag_ok) begin
          lag <= cnt;
          lag_ok <= 1'b1;
        end
      end
      if (closing) begin
        period <= cnt;
        rem <= lag_ok ? lag : '0;
        div_cnt <= '0;
      end else if (state == DIVIDE) begin
        rem <= rem_sh[CNT_W-1:0] - (q_bit ? period : '0);
        quo <= {quo[PHASE_BITS-2:0], q_bit};
        div_cnt <= div_cnt + DW'(1);
      end
    end
endmodule

// File: tb/tb_pword_measure.sv
// tb_pword_measure: randomized self-checking bench for pword_measure against an edge-event reference model
module tb_pword_measure;
  localparam int TO = 1000;
  localparam int MAXN = 2048;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic sig_ref = 1'b0;
  logic sig_dut = 1'b0;
  logic [23:0] Pword;
  logic pword_valid, busy, err_nodut, err_timeout;
  int errors = 0;
  int checks = 0;
  int n;
  int pw_last;
  bit wr[MAXN];
  bit wd[MAXN];
  bit we[MAXN];
  int exp_vc[$], exp_vp[$], exp_nd[$], exp_to[$];
  int got_vc[$], got_vp[$], got_nd[$], got_to[$];

  pword_measure #(.TIMEOUT(TO)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .sig_ref(sig_ref),
    .sig_dut(sig_dut),
    .Pword(Pword),
    .pword_valid(pword_valid),
    .busy(busy),
    .err_nodut(err_nodut),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit rb(input int i);
    return i >= 0 && i < n ? wr[i] : 1'b0;
  endfunction

  function automatic bit db(input int i);
    return i >= 0 && i < n ? wd[i] : 1'b0;
  endfunction

  function automatic bit redge(input int c);
    return rb(c - 2) && !rb(c - 3);
  endfunction

  function automatic bit dedge(input int c);
    return db(c - 2) && !db(c - 3);
  endfunction

  function automatic int next_redge(input int a);
    for (int c = a; c < n; c++) if (redge(c)) return c;
    return -1;
  endfunction

  function automatic int first_dedge(input int a, input int b);
    for (int c = a; c <= b && c < n; c++) if (dedge(c)) return c;
    return -1;
  endfunction

  function automatic int first_en(input int a);
    for (int c = a; c < n; c++) if (we[c]) return c;
    return n;
  endfunction

  function automatic int first_enlow(input int a, input int b);
    for (int c = a; c <= b && c < n; c++) if (!we[c]) return c;
    return -1;
  endfunction

  task automatic model();
    int c, s, r, e, d, lo, lag;
    bit closed;
    exp_vc.delete();
    exp_vp.delete();
    exp_nd.delete();
    exp_to.delete();
    c = first_en(0) + 1;
    while (c < n) begin
      s = next_redge(c);
      if (s < 0) break;
      lo = first_enlow(c, s);
      if (lo >= 0) begin
        c = first_en(lo + 1) + 1;
        continue;
      end
      r = next_redge(s + 1);
      closed = r >= 0 && r - s <= TO;
      e = closed ? r : s + TO;
      lo = first_enlow(s + 1, e - 1);
      if (lo >= 0) begin
        c = first_en(lo + 1) + 1;
        continue;
      end
      if (e >= n) break;
      d = first_dedge(s, e);
      if (!closed) exp_to.push_back(e);
      else if (d < 0) exp_nd.push_back(e);
      lo = (!closed || d < 0) ? first_enlow(e, e) : first_enlow(e, e + 21);
      if (lo >= 0) begin
        c = first_en(lo + 1) + 1;
        continue;
      end
      if (!closed || d < 0) begin
        c = e + 1;
        continue;
      end
      lag = d < e ? d - s : 0;
      if (e + 22 < n) begin
        exp_vc.push_back(e + 22);
        exp_vp.push_back(int'((longint'(lag) << 20) / (e - s)));
      end
      c = e + 22;
    end
  endtask

  task automatic wave(input int a, input int b, input int p, input int d, input bit dlow, input bit en_v);
    for (int k = a; k < b; k++) begin
      wr[k] = (k % p) < p / 2;
      wd[k] = !dlow && ((((k - d) % p) + p) % p) < p / 2;
      we[k] = en_v;
    end
  endtask

  task automatic compare(input string tag);
    check({tag, " valid_count"}, got_vc.size(), exp_vc.size());
    foreach (exp_vc[i])
      if (i < got_vc.size()) begin
        check({tag, " valid_cycle"}, got_vc[i], exp_vc[i]);
        check({tag, " pword"}, got_vp[i], exp_vp[i]);
      end
    check({tag, " nodut_count"}, got_nd.size(), exp_nd.size());
    foreach (exp_nd[i]) if (i < got_nd.size()) check({tag, " nodut_cycle"}, got_nd[i], exp_nd[i]);
    check({tag, " timeout_count"}, got_to.size(), exp_to.size());
    foreach (exp_to[i]) if (i < got_to.size()) check({tag, " timeout_cycle"}, got_to[i], exp_to[i]);
  endtask

  task automatic run_seg(input string tag, input int rst_at);
    got_vc.delete();
    got_vp.delete();
    got_nd.delete();
    got_to.delete();
    rst_n = 1'b0;
    en = 1'b0;
    sig_ref = 1'b0;
    sig_dut = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) check({tag, " reset_outputs"}, {Pword, pword_valid, busy, err_nodut, err_timeout}, 0);
      else check({tag, " busy"}, busy, we[k-1]);
      if (pword_valid) begin
        got_vc.push_back(k);
        got_vp.push_back(int'(Pword));
      end
      if (err_nodut) got_nd.push_back(k);
      if (err_timeout) got_to.push_back(k);
      if (k == n - 1) pw_last = int'(Pword);
      sig_ref = wr[k];
      sig_dut = wd[k];
      en = we[k];
      rst_n = 1'b1;
    end
    if (rst_at > 0) begin
      @(negedge clk);
      check({tag, " pre_reset_pword"}, Pword, 131072);
      #2 rst_n = 1'b0;
      #1 check({tag, " async_reset_outputs"}, {Pword, pword_valid, busy, err_nodut, err_timeout}, 0);
    end
    model();
    compare(tag);
    if (rst_at == 0) check({tag, " held_pword"}, pw_last, exp_vp.size() > 0 ? exp_vp[$] : 0);
  endtask

  initial begin
    int p, d, a, b;
    n = 800;
    wave(0, n, 80, 10, 1'b0, 1'b1);
    run_seg("delay10", 0);
    check("delay10 final_pword", pw_last, 131072);
    wave(0, n, 80, 20, 1'b0, 1'b1);
    run_seg("delay20", 0);
    check("delay20 final_pword", pw_last, 262144);
    wave(0, n, 80, 0, 1'b0, 1'b1);
    run_seg("delay0", 0);
    check("delay0 final_pword", pw_last, 0);
    wave(0, n, 80, 79, 1'b0, 1'b1);
    run_seg("delay79", 0);
    check("delay79 final_pword", pw_last, 1035468);
    n = 1000;
    wave(0, 400, 80, 10, 1'b0, 1'b1);
    wave(400, n, 80, 10, 1'b1, 1'b1);
    run_seg("nodut", 0);
    check("nodut held_after_errors", pw_last, 131072);
    check("nodut error_seen", got_nd.size() > 0, 1);
    n = 1100;
    for (int k = 0; k < n; k++) begin
      wr[k] = k >= 5;
      wd[k] = 1'b0;
      we[k] = 1'b1;
    end
    run_seg("timeout", 0);
    check("timeout first_cycle", got_to.size() > 0 ? got_to[0] : -1, 1007);
    n = 255;
    wave(0, n, 80, 10, 1'b0, 1'b1);
    run_seg("rst_divide", 255);
    n = 300;
    wave(0, n, 80, 10, 1'b0, 1'b1);
    run_seg("after_rst", 0);
    check("after_rst final_pword", pw_last, 131072);
    n = 600;
    wave(0, n, 80, 10, 1'b0, 1'b1);
    for (int k = 40; k < 60; k++) we[k] = 1'b0;
    run_seg("en_drop", 0);
    check("en_drop first_valid", got_vc.size() > 0 ? got_vc[0] : -1, 184);
    check("en_drop final_pword", pw_last, 131072);
    n = 1500;
    for (int s = 0; s < 6; s++) begin
      p = $urandom_range(4, 250);
      d = $urandom_range(0, p - 1);
      wave(0, 750, p, d, $urandom_range(0, 4) == 0, 1'b1);
      p = $urandom_range(4, 250);
      d = $urandom_range(0, p - 1);
      wave(750, n, p, d, $urandom_range(0, 4) == 0, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, 1400);
        b = a + $urandom_range(1, 60);
        for (int k = a; k < b && k < n; k++) we[k] = 1'b0;
      end
      run_seg("random", 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
